// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART interrupt path.
// Holds the arbiter FSM encoding and the default hold-off counter width.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SERVICE,
        HOLDOFF
    } uart_irq_arb_state_t;

    localparam int UART_IRQ_HOLDOFF_W_DEF = 8;

endpackage

// File: rtl/uart_irq_prio_sel.sv
// Combinational winner selection over the event IRQ vector.
// Rotates the request vector so the start pointer lands at bit 0, then finds the first set bit.
module uart_irq_prio_sel #(
    parameter int EVENTS_NUM = 32,
    parameter int ID_W       = (EVENTS_NUM > 1) ? $clog2(EVENTS_NUM) : 1
) (
    input  logic [EVENTS_NUM-1:0] i_req,
    input  logic [ID_W-1:0]       i_ptr,
    input  logic                  i_rr_en,
    output logic [ID_W-1:0]       o_idx,
    output logic                  o_any
);

    logic [ID_W-1:0]       w_start;
    logic [EVENTS_NUM-1:0] w_rot;
    logic [ID_W:0]         w_off;
    logic [ID_W:0]         w_sum;

    always_comb begin
        w_start = i_rr_en ? i_ptr : '0;
        w_rot   = EVENTS_NUM'({i_req, i_req} >> w_start);
        w_off   = '0;
        for (int unsigned i = EVENTS_NUM; i > 0; i--) begin
            if (w_rot[i-1]) begin
                w_off = (ID_W+1)'(i - 1);
            end
        end
        // Offset is relative to the rotated start; fold back into 0..EVENTS_NUM-1.
        w_sum = {1'b0, w_start} + w_off;
        if (w_sum >= (ID_W+1)'(EVENTS_NUM)) begin
            w_sum = w_sum - (ID_W+1)'(EVENTS_NUM);
        end
        o_idx = w_sum[ID_W-1:0];
        o_any = |i_req;
    end

endmodule

// File: rtl/uart_irq_arbiter.sv
// Serialises UART event IRQs onto one CPU interrupt line with ack/EOI handshake,
// fixed or round-robin priority, and a programmable hold-off after each EOI.
module uart_irq_arbiter
    import uart_pkg::*;
#(
    parameter int EVENTS_NUM = 32,
    parameter int ID_W       = (EVENTS_NUM > 1) ? $clog2(EVENTS_NUM) : 1,
    parameter int HOLDOFF_W  = UART_IRQ_HOLDOFF_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [EVENTS_NUM-1:0] i_irq_bus,
    input  logic                  i_rr_mode,
    input  logic [HOLDOFF_W-1:0]  i_holdoff,
    input  logic                  i_ack,
    input  logic                  i_eoi,
    output logic                  o_irq,
    output logic [ID_W-1:0]       o_irq_id,
    output logic                  o_irq_id_valid,
    output logic [EVENTS_NUM-1:0] o_in_service,
    output logic                  o_busy,
    output logic                  o_spurious
);

    uart_irq_arb_state_t r_state, w_state_nxt;
    logic [ID_W-1:0]      r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]      r_id, w_id_nxt;
    logic [HOLDOFF_W-1:0] r_cnt, w_cnt_nxt;
    logic                 r_spurious, w_spurious_nxt;

    logic [ID_W-1:0]      w_sel_idx;
    logic                 w_sel_any;

    uart_irq_prio_sel #(
        .EVENTS_NUM (EVENTS_NUM),
        .ID_W       (ID_W)
    ) u_prio_sel (
        .i_req   (i_irq_bus),
        .i_ptr   (r_ptr),
        .i_rr_en (i_rr_mode),
        .o_idx   (w_sel_idx),
        .o_any   (w_sel_any)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_cnt      <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_id       <= w_id_nxt;
            r_cnt      <= w_cnt_nxt;
            r_spurious <= w_spurious_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_id_nxt       = r_id;
        w_cnt_nxt      = r_cnt;
        w_spurious_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_any) begin
                    w_id_nxt    = w_sel_idx;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                // Ack takes precedence over a request line dropping in the same cycle.
                if (i_ack) begin
                    w_state_nxt = SERVICE;
                    if (i_rr_mode) begin
                        w_ptr_nxt = (r_id == ID_W'(EVENTS_NUM - 1)) ? '0 : r_id + ID_W'(1);
                    end
                end else if (!i_irq_bus[r_id]) begin
                    w_spurious_nxt = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            SERVICE: begin
                if (i_eoi) begin
                    if (i_holdoff == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = i_holdoff;
                        w_state_nxt = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (r_cnt <= HOLDOFF_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - HOLDOFF_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_irq          = (r_state == PEND);
        o_irq_id       = r_id;
        o_irq_id_valid = (r_state == PEND) || (r_state == SERVICE);
        o_busy         = (r_state != IDLE);
        o_spurious     = r_spurious;
        o_in_service   = '0;
        for (int unsigned i = 0; i < EVENTS_NUM; i++) begin
            o_in_service[i] = (r_state == SERVICE) && (r_id == ID_W'(i));
        end
    end

endmodule

// File: doc/uart_irq_arbiter.md
Name: uart_irq_arbiter

Overview:
- Sits downstream of the UART IRQ generator and consumes its per-event IRQ bus.
- Serialises concurrent event IRQs onto a single CPU interrupt line, with an ID/vector output.
- Runs an ack / end-of-interrupt (EOI) handshake with software.
- Enforces a programmable hold-off gap between serviced interrupts; priority is fixed or round-robin, selected at run time.

Parameters:
- EVENTS_NUM, 32, number of event IRQ lines (1..32).
- ID_W, $clog2(EVENTS_NUM) (min 1), width of the interrupt ID.
- HOLDOFF_W, 8, width of the hold-off counter.

Ports:
- i_clk  input  1  system clock; single clock domain.
- i_nrst  input  1  asynchronous, active-low reset.
- i_irq_bus  input  EVENTS_NUM  level IRQs from the IRQ generator, already masked.
- i_rr_mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- i_holdoff  input  HOLDOFF_W  idle cycles enforced after EOI; sampled at EOI.
- i_ack  input  1  single-cycle pulse: CPU has read o_irq_id.
- i_eoi  input  1  single-cycle pulse: CPU has finished servicing.
- o_irq  output  1  CPU interrupt line, registered.
- o_irq_id  output  ID_W  index of the current winner; held from selection until EOI.
- o_irq_id_valid  output  1  high in PEND and SERVICE.
- o_in_service  output  EVENTS_NUM  one-hot of the event in service (SERVICE only).
- o_busy  output  1  high in any state other than IDLE.
- o_spurious  output  1  one-cycle pulse when the winner drops before ack.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, hold-off counter 0. Assertion mid-operation aborts immediately; no pending state is retained.
- States: IDLE, PEND, SERVICE, HOLDOFF, held in a registered FSM.
- IDLE:
  - If |i_irq_bus, latch the winner into id_q and go to PEND.
  - o_irq, o_irq_id_valid and o_busy rise in the following cycle (edge N to N+1, 1-cycle latency).
- PEND (o_irq=1):
  - If i_ack: go to SERVICE, o_irq=0 next cycle, o_in_service[id_q]=1. If i_rr_mode=1, the RR pointer becomes (id_q+1) mod EVENTS_NUM.
  - Else if i_irq_bus[id_q]==0: pulse o_spurious, o_irq=0, go to IDLE. No re-arbitration in the same cycle.
  - If i_ack and the line drop coincide, ack wins (no spurious pulse).
- SERVICE:
  - On i_eoi, sample i_holdoff. If 0, go to IDLE; else load the counter with i_holdoff and go to HOLDOFF.
  - o_in_service clears on the EOI edge.
- HOLDOFF:
  - Counter decrements each cycle; at count 1 go to IDLE.
  - Exactly i_holdoff cycles elapse in HOLDOFF, and no arbitration happens there.
- Out-of-state strobes are ignored with no side effects: i_ack outside PEND, i_eoi outside SERVICE.
- Selection (combinational, from i_irq_bus in IDLE):
  - Fixed mode: lowest set index.
  - RR mode: first set index at or above the pointer, wrapping modulo EVENTS_NUM.
  - A single requester always wins regardless of the pointer.
  - The pointer does not change when i_rr_mode=0, but the last value persists across mode switches.
- Other boundary rules:
  - The i_rr_mode change takes effect at the next IDLE selection.
  - i_irq_bus changes during SERVICE/HOLDOFF do not affect o_irq_id.
  - With EVENTS_NUM=1, o_irq_id is constant 0.

Decomposition:
- uart_pkg adds:
  - typedef enum logic [1:0] uart_irq_arb_state_t {IDLE, PEND, SERVICE, HOLDOFF};
  - localparam UART_IRQ_HOLDOFF_W_DEF = 8.
- Sub-module uart_irq_prio_sel (purely combinational, parameter EVENTS_NUM):
  - Inputs: request vector, start pointer, rr enable.
  - Outputs: winner index and any-request flag.
  - Implemented as a double-width rotate plus find-first-set.
- The arbiter holds only the FSM, the pointer, id_q and the hold-off counter.

Test Plan:
- Fixed priority (EVENTS_NUM=8, rr=0): i_irq_bus=8'b0010_0100. o_irq rises 1 cycle later with id=2. Ack then EOI (holdoff=0) → next round id=2 again while bit 2 is still set; after bit 2 clears, id=5.
- Round-robin (rr=1): bus=8'hFF held, ack+EOI each round, holdoff=0 → ids 0,1,2,…,7,0. Pointer wraps at 7.
- Spurious: bus=8'h10, drop bit 4 while in PEND, no ack → o_spurious is a 1-cycle pulse, o_irq=0, state IDLE, pointer unchanged. Same case with ack in the drop cycle → SERVICE, no spurious pulse.
- Hold-off: holdoff=5, EOI while bus=8'h01 is pending → o_busy stays 1 and o_irq stays 0 for exactly 5 cycles; o_irq rises on cycle 7 after EOI.
- Stray strobes: i_eoi in PEND and i_ack in SERVICE/IDLE → no state change and outputs unchanged. Second ack in SERVICE → o_in_service unchanged.
- Reset mid-SERVICE: assert i_nrst=0 asynchronously with id=3 in service → all outputs 0 immediately. After release with bus=0, the block stays IDLE and the RR pointer is 0.
